// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped UART for the FemtoRV IO page, with RX/TX FIFOs.
// It contains its own baud timing, receive/transmit shifters, sticky error
// flags, FIFO level readout and break-character detection.
// Ports:
//   clk, resetq         system clock, asynchronous active-low reset
//   rstrb, wstrb        bus read / write strobes
//   sel_dat, sel_cntl   register selects (data, control/status)
//   wdata, rdata        bus write data / combinational read data
//   RXD, TXD            serial line in (asynchronous) / out
//   brk                 one-cycle pulse when BRK_CHAR is received
module uart_fifo #(
  parameter int         FREQ_MHZ = 60,
  parameter int         BAUDS    = 115200,
  parameter int         RX_DEPTH = 16,
  parameter int         TX_DEPTH = 16,
  parameter logic [7:0] BRK_CHAR = 8'd3
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        rstrb,
  input  logic        wstrb,
  input  logic        sel_dat,
  input  logic        sel_cntl,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        RXD,
  output logic        TXD,
  output logic        brk
);
  localparam int DIV = FREQ_MHZ * 1000000 / BAUDS;
  localparam int CW  = $clog2(DIV);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic dat_rd_s, dat_wr_s, cntl_wr_s, flag_clr_s, flush_s, wdata_unused_s;
  assign dat_rd_s       = sel_dat & rstrb;
  assign dat_wr_s       = sel_dat & wstrb;
  assign cntl_wr_s      = sel_cntl & wstrb;
  assign flag_clr_s     = cntl_wr_s & wdata[0];
  assign flush_s        = cntl_wr_s & wdata[1];
  assign wdata_unused_s = ^wdata[31:8];

  // ---------------- RX FIFO ----------------
  logic [7:0]     rx_mem_r [RX_DEPTH];
  logic [RAW-1:0] rx_wp_r, rx_rp_r;
  logic [RAW:0]   rx_lvl_r;
  logic           rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_req_s, rx_ferr_s;
  logic [7:0]     rx_byte_s, rx_head_s;

  assign rx_empty_s = (rx_lvl_r == (RAW+1)'(0));
  assign rx_full_s  = (rx_lvl_r == (RAW+1)'(RX_DEPTH));
  assign rx_pop_s   = dat_rd_s & ~rx_empty_s;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign rx_push_s  = rx_req_s & (~rx_full_s | rx_pop_s);
  assign rx_head_s  = rx_empty_s ? 8'd0 : rx_mem_r[rx_rp_r];

  // RX FIFO pointers and level; flush overrides push and pop
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_wp_r  <= RAW'(0);
      rx_rp_r  <= RAW'(0);
      rx_lvl_r <= (RAW+1)'(0);
    end else if (flush_s) begin
      rx_wp_r  <= RAW'(0);
      rx_rp_r  <= RAW'(0);
      rx_lvl_r <= (RAW+1)'(0);
    end else begin
      if (rx_push_s) rx_wp_r <= rx_wp_r + RAW'(1);
      if (rx_pop_s)  rx_rp_r <= rx_rp_r + RAW'(1);
      rx_lvl_r <= rx_lvl_r + (RAW+1)'(rx_push_s) - (RAW+1)'(rx_pop_s);
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_r[rx_wp_r] <= rx_byte_s;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]     tx_mem_r [TX_DEPTH];
  logic [TAW-1:0] tx_wp_r, tx_rp_r;
  logic [TAW:0]   tx_lvl_r;
  logic           tx_empty_s, tx_full_s, tx_pop_s, tx_push_s;
  logic [7:0]     tx_head_s;

  assign tx_empty_s = (tx_lvl_r == (TAW+1)'(0));
  assign tx_full_s  = (tx_lvl_r == (TAW+1)'(TX_DEPTH));
  assign tx_push_s  = dat_wr_s & (~tx_full_s | tx_pop_s);
  assign tx_head_s  = tx_mem_r[tx_rp_r];

  // TX FIFO pointers and level; flush overrides push and pop
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_wp_r  <= TAW'(0);
      tx_rp_r  <= TAW'(0);
      tx_lvl_r <= (TAW+1)'(0);
    end else if (flush_s) begin
      tx_wp_r  <= TAW'(0);
      tx_rp_r  <= TAW'(0);
      tx_lvl_r <= (TAW+1)'(0);
    end else begin
      if (tx_push_s) tx_wp_r <= tx_wp_r + TAW'(1);
      if (tx_pop_s)  tx_rp_r <= tx_rp_r + TAW'(1);
      tx_lvl_r <= tx_lvl_r + (TAW+1)'(tx_push_s) - (TAW+1)'(tx_pop_s);
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wp_r] <= wdata[7:0];
  end

  // ---------------- flags and break ----------------
  logic overrun_r, frame_err_r, brk_r;

  // sticky flags: a new event in the clearing cycle wins over the clear
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      brk_r       <= 1'b0;
    end else begin
      overrun_r   <= (overrun_r & ~flag_clr_s) | (rx_req_s & rx_full_s & ~rx_pop_s);
      frame_err_r <= (frame_err_r & ~flag_clr_s) | rx_ferr_s;
      brk_r       <= rx_req_s & (rx_byte_s == BRK_CHAR);
    end
  end
  assign brk = brk_r;

  // ---------------- receiver ----------------
  logic            rx_meta_r, rxs_r, rx_tick_s;
  rx_state_t       rx_state_r, rx_state_nx_s;
  logic [CW-1:0]   rx_tmr_r, rx_tmr_nx_s;
  logic [2:0]      rx_bit_r, rx_bit_nx_s;
  logic [7:0]      rx_shf_r, rx_shf_nx_s;

  assign rx_tick_s = (rx_tmr_r == CW'(0));
  assign rx_byte_s = rx_shf_r;

  // two-flop synchroniser for the asynchronous RXD line (idles high)
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= RXD;
      rxs_r     <= rx_meta_r;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) rx_state_r <= RX_IDLE;
    else         rx_state_r <= rx_state_nx_s;
  end

  // RX next-state logic
  always_comb begin
    rx_state_nx_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE:  if (!rxs_r) rx_state_nx_s = RX_START; else rx_state_nx_s = RX_IDLE;
      RX_START: if (rx_tick_s) rx_state_nx_s = rxs_r ? RX_IDLE : RX_DATA;
                else rx_state_nx_s = RX_START;
      RX_DATA:  if (rx_tick_s && rx_bit_r == 3'd7) rx_state_nx_s = RX_STOP;
                else rx_state_nx_s = RX_DATA;
      RX_STOP:  if (rx_tick_s) rx_state_nx_s = rxs_r ? RX_IDLE : RX_WAIT;
                else rx_state_nx_s = RX_STOP;
      RX_WAIT:  if (rxs_r) rx_state_nx_s = RX_IDLE; else rx_state_nx_s = RX_WAIT;
      default:  rx_state_nx_s = RX_IDLE;
    endcase
  end

  // RX datapath: bit timer, shifter, and push / framing-error requests
  always_comb begin
    rx_tmr_nx_s = rx_tmr_r;
    rx_bit_nx_s = rx_bit_r;
    rx_shf_nx_s = rx_shf_r;
    rx_req_s    = 1'b0;
    rx_ferr_s   = 1'b0;
    case (rx_state_r)
      // first expiry lands mid start bit
      RX_IDLE:  if (!rxs_r) rx_tmr_nx_s = HALF_M1; else rx_tmr_nx_s = rx_tmr_r;
      RX_START: if (rx_tick_s) begin
                  rx_tmr_nx_s = DIV_M1;
                  rx_bit_nx_s = 3'd0;
                end else rx_tmr_nx_s = rx_tmr_r - CW'(1);
      RX_DATA:  if (rx_tick_s) begin
                  rx_tmr_nx_s = DIV_M1;
                  rx_shf_nx_s = {rxs_r, rx_shf_r[7:1]};
                  rx_bit_nx_s = rx_bit_r + 3'd1;
                end else rx_tmr_nx_s = rx_tmr_r - CW'(1);
      RX_STOP:  if (rx_tick_s) begin
                  rx_req_s  = rxs_r;
                  rx_ferr_s = ~rxs_r;
                end else rx_tmr_nx_s = rx_tmr_r - CW'(1);
      RX_WAIT:  rx_tmr_nx_s = rx_tmr_r;
      default:  rx_tmr_nx_s = rx_tmr_r;
    endcase
  end

  // RX datapath registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_tmr_r <= CW'(0);
      rx_bit_r <= 3'd0;
      rx_shf_r <= 8'd0;
    end else begin
      rx_tmr_r <= rx_tmr_nx_s;
      rx_bit_r <= rx_bit_nx_s;
      rx_shf_r <= rx_shf_nx_s;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t     tx_state_r, tx_state_nx_s;
  logic [CW-1:0] tx_tmr_r, tx_tmr_nx_s;
  logic [2:0]    tx_bit_r, tx_bit_nx_s;
  logic [7:0]    tx_shf_r, tx_shf_nx_s;
  logic          txd_r, txd_nx_s, tx_tick_s;

  assign tx_tick_s = (tx_tmr_r == CW'(0));
  // a queued byte starts straight out of the stop bit for gap-free frames;
  // a flush in the same cycle cancels the start
  assign tx_pop_s  = ~tx_empty_s & ~flush_s &
                     ((tx_state_r == TX_IDLE) | ((tx_state_r == TX_STOP) & tx_tick_s));
  assign TXD       = txd_r;

  // TX state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) tx_state_r <= TX_IDLE;
    else         tx_state_r <= tx_state_nx_s;
  end

  // TX next-state logic
  always_comb begin
    tx_state_nx_s = tx_state_r;
    case (tx_state_r)
      TX_IDLE:  if (tx_pop_s) tx_state_nx_s = TX_START; else tx_state_nx_s = TX_IDLE;
      TX_START: if (tx_tick_s) tx_state_nx_s = TX_DATA; else tx_state_nx_s = TX_START;
      TX_DATA:  if (tx_tick_s && tx_bit_r == 3'd7) tx_state_nx_s = TX_STOP;
                else tx_state_nx_s = TX_DATA;
      TX_STOP:  if (tx_tick_s) tx_state_nx_s = tx_pop_s ? TX_START : TX_IDLE;
                else tx_state_nx_s = TX_STOP;
      default:  tx_state_nx_s = TX_IDLE;
    endcase
  end

  // TX datapath: next line level, bit timer and shifter
  always_comb begin
    txd_nx_s    = txd_r;
    tx_tmr_nx_s = tx_tmr_r;
    tx_bit_nx_s = tx_bit_r;
    tx_shf_nx_s = tx_shf_r;
    if (tx_pop_s) begin
      txd_nx_s    = 1'b0;
      tx_tmr_nx_s = DIV_M1;
      tx_bit_nx_s = 3'd0;
      tx_shf_nx_s = tx_head_s;
    end else begin
      case (tx_state_r)
        TX_IDLE:  txd_nx_s = 1'b1;
        TX_START: if (tx_tick_s) begin
                    txd_nx_s    = tx_shf_r[0];
                    tx_tmr_nx_s = DIV_M1;
                  end else tx_tmr_nx_s = tx_tmr_r - CW'(1);
        TX_DATA:  if (tx_tick_s) begin
                    tx_tmr_nx_s = DIV_M1;
                    if (tx_bit_r == 3'd7) txd_nx_s = 1'b1;
                    else begin
                      txd_nx_s    = tx_shf_r[1];
                      tx_shf_nx_s = {1'b0, tx_shf_r[7:1]};
                      tx_bit_nx_s = tx_bit_r + 3'd1;
                    end
                  end else tx_tmr_nx_s = tx_tmr_r - CW'(1);
        TX_STOP:  if (tx_tick_s) txd_nx_s = 1'b1;
                  else tx_tmr_nx_s = tx_tmr_r - CW'(1);
        default:  txd_nx_s = 1'b1;
      endcase
    end
  end

  // TX datapath registers; the line idles high
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      txd_r    <= 1'b1;
      tx_tmr_r <= CW'(0);
      tx_bit_r <= 3'd0;
      tx_shf_r <= 8'd0;
    end else begin
      txd_r    <= txd_nx_s;
      tx_tmr_r <= tx_tmr_nx_s;
      tx_bit_r <= tx_bit_nx_s;
      tx_shf_r <= tx_shf_nx_s;
    end
  end

  // ---------------- read mux ----------------
  // register read data, selected by the decoder
  always_comb begin
    if (sel_dat)
      rdata = {22'd0, tx_full_s, ~rx_empty_s, rx_head_s};
    else if (sel_cntl)
      rdata = {8'(tx_lvl_r), 8'(rx_lvl_r), 4'd0, frame_err_r, overrun_r,
               tx_full_s, ~rx_empty_s, 8'd0};
    else
      rdata = 32'd0;
  end
endmodule
